// File: rtl/apb_arb_master.sv
// Round-robin arbiter in front of a single APB master port.
// Serves one latched request at a time and reports completion to its owner.
module apb_arb_master #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             busy,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           gnt_q, gnt_d;
    logic [CW-1:0]           tmo_q, tmo_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    logic                    grant_any;
    logic [PW-1:0]           grant_idx;
    logic [PW-1:0]           scan_idx;
    logic [PW-1:0]           ptr_next;

    // Search upward from the pointer with wrap; first hit wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        if (grant_idx == PW'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        tmo_d       = tmo_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    paddr_d  = addr_arr[grant_idx];
                    pwdata_d = wdata_arr[grant_idx];
                    pwrite_d = req_write[grant_idx];
                    psel_d   = 1'b1;
                    gnt_d    = grant_idx;
                    ptr_d    = ptr_next;
                    tmo_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // PREADY takes priority over an expiring timeout.
                if (PREADY) begin
                    psel_d             = 1'b0;
                    penable_d          = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d          = PSLVERR;
                    rsp_rdata_d        = pwrite_q ? '0 : PRDATA;
                    tmo_d              = '0;
                    state_d            = S_IDLE;
                end else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    psel_d             = 1'b0;
                    penable_d          = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    rsp_rdata_d        = '0;
                    tmo_d              = '0;
                    state_d            = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            tmo_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            tmo_q       <= tmo_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- Multi-requester APB master that shares one APB completer (e.g. the memory-mapped APB slave) between NUM_REQ internal requesters.
- Performs round-robin arbitration, latches the winning request, and runs the APB SETUP/ACCESS sequence.
- Waits on PREADY with a timeout, then returns read data and error status to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 16, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort (>=2).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_write  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same slicing.
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational, IDLE state only.
- rsp_valid  out  NUM_REQ  one-hot 1-cycle completion pulse, registered.
- rsp_rdata  out  DATA_WIDTH  read data; valid while any rsp_valid bit is high.
- rsp_err  out  1  PSLVERR or timeout; valid with rsp_valid.
- busy  out  1  high in SETUP/ACCESS.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (async):
  - state=IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - RR pointer = 0, timeout counter = 0.
  - Reset asserted mid-transfer drops PSEL/PENABLE immediately. The in-flight request is lost and no rsp_valid is issued.
- FSM states: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching from the pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[g]=1 combinationally in that cycle; all other req_ready bits are 0.
  - On the clock edge: latch req_addr[g], req_wdata[g], req_write[g] into PADDR/PWDATA/PWRITE; PSEL<=1; pointer<=(g+1) mod NUM_REQ; go to SETUP.
  - No valid requests: stay in IDLE, PSEL=0, PADDR/PWDATA/PWRITE hold their last values.
- SETUP: exactly 1 cycle with PSEL=1, PENABLE=0; then PENABLE<=1 and go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA are stable from SETUP until exit.
  - PREADY sampled 1 on an edge:
    - PSEL<=0, PENABLE<=0.
    - rsp_valid[g]<=1 for one cycle.
    - rsp_err<=PSLVERR.
    - rsp_rdata<=PRDATA for reads; 0 for writes.
    - Go to IDLE.
  - Timeout counter increments on each ACCESS edge without PREADY. If PREADY is still 0 on the TIMEOUT_CYCLES-th ACCESS edge, exit as above with rsp_err=1 and rsp_rdata=0.
- Latency:
  - Minimum grant-to-rsp_valid is 3 cycles, for a completer with zero wait states.
  - Back-to-back transfers: a new grant is possible in the same cycle rsp_valid is high. PSEL then deasserts for exactly 1 cycle between transfers.
- Requester rules:
  - req_valid may drop before grant; such a request is not served.
  - Request fields are sampled only on the grant edge.
  - A requester may re-request in the cycle its rsp_valid is high. Round-robin guarantees every other pending requester is served first.
- rsp_rdata/rsp_err hold their values after the pulse until the next completion.
- Simultaneous events: PREADY and timeout on the same edge are treated as a normal PREADY completion, with PSLVERR honoured.

Test Plan:
- Single write then read by requester 1: write addr 0x0010 data 0xDEADBEEF, then read 0x0010 -> APB shows SETUP (PSEL=1, PENABLE=0) then ACCESS; read returns rsp_valid=4'b0010, rsp_rdata=0xDEADBEEF, rsp_err=0.
- All 4 requesters hold req_valid continuously after reset -> grant order 0,1,2,3,0; each rsp_valid one-hot matches its grant; PSEL low exactly 1 cycle between transfers.
- Completer holds PREADY low 3 ACCESS cycles -> PADDR/PWDATA/PWRITE stable throughout; rsp_valid appears 1 cycle after the PREADY edge.
- PREADY=1 with PSLVERR=1 on a read of 0x0400 -> rsp_err=1, rsp_rdata equals PRDATA; the next transfer completes with rsp_err=0.
- PREADY tied low, TIMEOUT_CYCLES=16 -> exit after 16 ACCESS edges; rsp_err=1, rsp_rdata=0; FSM returns to IDLE and serves the next request.
- rst_n asserted during ACCESS -> PSEL/PENABLE go 0 immediately; no rsp_valid; after release the first grant goes to requester 0 (pointer reset).
